// File: rtl/osd_overlay.sv
// OSD mixer behind the scandoubler: measures the incoming raster and overlays a centred
// 256x64 monochrome bitmap, with each bitmap line shown twice, on the doubled video stream.
module osd_overlay #(
   parameter logic [9:0] OSD_X_OFF = 10'd0,
   parameter logic [9:0] OSD_Y_OFF = 10'd0,
   parameter logic [2:0] OSD_COLOR = 3'd4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ce_pix,
   input  logic        osd_enable,
   input  logic        cfg_we,
   input  logic [10:0] cfg_addr,
   input  logic [7:0]  cfg_data,
   input  logic        hs_in,
   input  logic        vs_in,
   input  logic [5:0]  r_in,
   input  logic [5:0]  g_in,
   input  logic [5:0]  b_in,
   output logic        hs_out,
   output logic        vs_out,
   output logic [5:0]  r_out,
   output logic [5:0]  g_out,
   output logic [5:0]  b_out
);

   logic [7:0]  mem [0:2047];
   logic [7:0]  rd_q;

   logic        hs_prev, vs_prev, en_q;
   logic [9:0]  hcnt_q, vcnt_q, h_total, v_total;
   logic        hs_fall, vs_fall, active, in_win;
   logic [9:0]  hx, vy, vinc, h_start, v_start;
   logic [10:0] h_end, v_end;
   logic [7:0]  ox;
   logic [6:0]  oy;
   logic [10:0] rd_addr;

   logic        win_q, hs1_q, vs1_q;
   logic [2:0]  sel_q;
   logic [5:0]  r1_q, g1_q, b1_q;
   logic [5:0]  r_mix, g_mix, b_mix;

   assign hs_fall = hs_prev & ~hs_in;
   assign vs_fall = vs_prev & ~vs_in;

   // hcnt_q holds the index of the next pixel, so at hs fall it equals the line length.
   assign hx   = hs_fall ? 10'd0 : hcnt_q;
   assign vinc = (hs_fall && vcnt_q != 10'h3FF) ? vcnt_q + 10'd1 : vcnt_q;
   assign vy   = vs_fall ? 10'd0 : vinc;

   assign h_start = ((h_total - 10'd256) >> 1) + OSD_X_OFF;
   assign v_start = ((v_total - 10'd128) >> 1) + OSD_Y_OFF;
   assign h_end   = {1'b0, h_start} + 11'd256;
   assign v_end   = {1'b0, v_start} + 11'd128;

   assign active = en_q && (h_total >= 10'd256) && (v_total >= 10'd128);
   assign in_win = active && (hx >= h_start) && ({1'b0, hx} < h_end) &&
                   (vy >= v_start) && ({1'b0, vy} < v_end);

   assign ox      = hx[7:0] - h_start[7:0];
   assign oy      = vy[6:0] - v_start[6:0];
   assign rd_addr = {oy[6:4], ox};

   // Bitmap RAM: registered read returns old data on a same-address write.
   always_ff @(posedge clk_sys) begin
      if (cfg_we) mem[cfg_addr] <= cfg_data;
      if (ce_pix) rd_q <= mem[rd_addr];
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hs_prev <= 1'b1;
         vs_prev <= 1'b1;
         hcnt_q  <= 10'd0;
         vcnt_q  <= 10'd0;
         h_total <= 10'd0;
         v_total <= 10'd0;
         en_q    <= 1'b0;
         win_q   <= 1'b0;
         sel_q   <= 3'd0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         r1_q    <= 6'd0;
         g1_q    <= 6'd0;
         b1_q    <= 6'd0;
         hs_out  <= 1'b1;
         vs_out  <= 1'b1;
         r_out   <= 6'd0;
         g_out   <= 6'd0;
         b_out   <= 6'd0;
      end else if (ce_pix) begin
         hs_prev <= hs_in;
         vs_prev <= vs_in;
         hcnt_q  <= (hx == 10'h3FF) ? hx : hx + 10'd1;
         vcnt_q  <= vy;
         if (hs_fall) h_total <= hcnt_q;
         if (vs_fall) begin
            v_total <= vinc;
            en_q    <= osd_enable;
         end
         win_q   <= in_win;
         sel_q   <= oy[3:1];
         hs1_q   <= hs_in;
         vs1_q   <= vs_in;
         r1_q    <= r_in;
         g1_q    <= g_in;
         b1_q    <= b_in;
         hs_out  <= hs1_q;
         vs_out  <= vs1_q;
         r_out   <= r_mix;
         g_out   <= g_mix;
         b_out   <= b_mix;
      end
   end

   always_comb begin
      r_mix = r1_q;
      g_mix = g1_q;
      b_mix = b1_q;
      if (win_q) begin
         if (rd_q[sel_q]) begin
            r_mix = 6'h3F;
            g_mix = 6'h3F;
            b_mix = 6'h3F;
         end else begin
            r_mix = {OSD_COLOR[2], r1_q[5:1]};
            g_mix = {OSD_COLOR[1], g1_q[5:1]};
            b_mix = {OSD_COLOR[0], b1_q[5:1]};
         end
      end
   end

endmodule

// File: tb/tb_osd_overlay.sv
// Directed bench for osd_overlay: 525-line frames with mostly short lines, long lines only
// where the window is probed, so each frame stays cheap while keeping the 800x525 geometry.
module tb_osd_overlay;

   logic        clk_sys = 1'b0;
   logic        reset_n, ce_pix, osd_enable, cfg_we;
   logic [10:0] cfg_addr;
   logic [7:0]  cfg_data;
   logic        hs_in, vs_in;
   logic [5:0]  r_in, g_in, b_in;
   logic        hs_out, vs_out;
   logic [5:0]  r_out, g_out, b_out;

   osd_overlay dut (
      .clk_sys    (clk_sys),
      .reset_n    (reset_n),
      .ce_pix     (ce_pix),
      .osd_enable (osd_enable),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .hs_in      (hs_in),
      .vs_in      (vs_in),
      .r_in       (r_in),
      .g_in       (g_in),
      .b_in       (b_in),
      .hs_out     (hs_out),
      .vs_out     (vs_out),
      .r_out      (r_out),
      .g_out      (g_out),
      .b_out      (b_out)
   );

   always #5 clk_sys = ~clk_sys;

   localparam logic [19:0] RstOut = 20'hC0000;
   localparam logic [17:0] Pass3f = 18'h3FFFF;
   localparam logic [17:0] Dark3f = {6'h3F, 6'h1F, 6'h1F};

   int          n_chk = 0;
   int          n_fail = 0;
   int          pass_err = 0;
   int          sync_err = 0;
   int          hold_err = 0;
   int          line_len [0:524];
   logic [17:0] obuf [0:524][0:799];
   logic [19:0] last_out;
   logic [19:0] prev_in;
   bit          pv;
   bit          chk_pass;
   int          prev_line, prev_pix;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] cur_out();
      return {hs_out, vs_out, r_out, g_out, b_out};
   endfunction

   task automatic cfg_write(input logic [10:0] a, input logic [7:0] d);
      cfg_we = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(posedge clk_sys);
      #1;
      cfg_we = 1'b0;
   endtask

   // One pixel; output captured after the edge belongs to the previous pixel.
   task automatic tick(input logic hs, input logic vs, input logic [5:0] r, input logic [5:0] g,
                       input logic [5:0] b, input int line, input int pix, input bit idle);
      logic [19:0] o;
      if (idle) begin
         ce_pix = 1'b0;
         @(posedge clk_sys);
         #1;
         if (cur_out() !== last_out) hold_err++;
      end
      ce_pix = 1'b1;
      hs_in = hs;
      vs_in = vs;
      r_in = r;
      g_in = g;
      b_in = b;
      @(posedge clk_sys);
      #1;
      o = cur_out();
      if (pv) begin
         if (o[19:18] !== prev_in[19:18]) sync_err++;
         if (chk_pass && o[17:0] !== prev_in[17:0]) pass_err++;
         if (prev_pix < 800) obuf[prev_line][prev_pix] = o[17:0];
      end
      last_out = o;
      prev_in = {hs, vs, r, g, b};
      prev_line = line;
      prev_pix = pix;
      pv = 1'b1;
      ce_pix = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_async", cur_out(), RstOut);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #3;
      reset_n = 1'b1;
      pv = 1'b0;
      last_out = RstOut;
      chk_pass = 1'b1;
   endtask

   task automatic set_lens(input int a, input int b, input int len);
      for (int l = a; l <= b; l++) line_len[l] = len;
   endtask

   // rgb_mode 0: all 6'h3F, 1: pattern; pass_mode 2: check only lines shorter than 256
   task automatic run_frame(input int rgb_mode, input int pass_mode, input int tog_line,
                            input bit tog_val, input int rst_line, input bit idle_on);
      logic [9:0] pl, ll;
      logic [5:0] r, g, b;
      for (int line = 0; line < 525; line++) begin
         if (pass_mode == 2) chk_pass = (line_len[line] < 256);
         if (line == tog_line) osd_enable = tog_val;
         ll = line[9:0];
         for (int pix = 0; pix < line_len[line]; pix++) begin
            if (line == rst_line && pix == 400) do_reset();
            pl = pix[9:0];
            if (rgb_mode == 0) begin
               r = 6'h3F;
               g = 6'h3F;
               b = 6'h3F;
            end else begin
               r = pl[5:0];
               g = ll[5:0];
               b = pl[5:0] ^ ll[5:0];
            end
            tick(pix >= 2, line >= 3, r, g, b, line, pix,
                 idle_on && line_len[line] >= 256 && (pix % 5) == 2);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0;
      ce_pix = 1'b0;
      osd_enable = 1'b0;
      cfg_we = 1'b0;
      cfg_addr = 11'd0;
      cfg_data = 8'd0;
      hs_in = 1'b1;
      vs_in = 1'b1;
      r_in = 6'd0;
      g_in = 6'd0;
      b_in = 6'd0;
      pv = 1'b0;
      chk_pass = 1'b0;
      last_out = RstOut;
      repeat (3) @(posedge clk_sys);
      #1;
      check("reset_out", cur_out(), RstOut);
      reset_n = 1'b1;
      for (int a = 0; a < 2048; a++) cfg_write(a[10:0], 8'h00);
      check("idle_out", cur_out(), RstOut);

      // Frames 0/1: overlay disabled, pass-through with ce_pix gaps
      set_lens(0, 524, 4);
      set_lens(196, 200, 800);
      chk_pass = 1'b1;
      run_frame(1, 1, -1, 1'b0, -1, 1'b1);
      check("pass_f0", pass_err, 0);
      pass_err = 0;
      run_frame(1, 1, -1, 1'b0, -1, 1'b1);
      check("pass_f1", pass_err, 0);
      pass_err = 0;

      // Frame 2: blank bitmap, window tint
      osd_enable = 1'b1;
      chk_pass = 1'b0;
      set_lens(324, 326, 800);
      run_frame(0, 0, -1, 1'b0, -1, 1'b0);
      check("f2_v197", obuf[197][300], Pass3f);
      check("f2_h271", obuf[198][271], Pass3f);
      check("f2_h272", obuf[198][272], Dark3f);
      check("f2_h527", obuf[198][527], Dark3f);
      check("f2_h528", obuf[198][528], Pass3f);
      check("f2_v325", obuf[325][400], Dark3f);
      check("f2_v326", obuf[326][400], Pass3f);

      // Frame 3: one lit bitmap pixel, enable dropped at line 300
      cfg_write(11'h000, 8'h01);
      set_lens(326, 326, 4);
      run_frame(0, 0, 300, 1'b0, -1, 1'b0);
      check("f3_lit198", obuf[198][272], Pass3f);
      check("f3_lit199", obuf[199][272], Pass3f);
      check("f3_dark200", obuf[200][272], Dark3f);
      check("f3_dark273", obuf[198][273], Dark3f);
      check("f3_no_tear", obuf[325][400], Dark3f);

      // Frame 4: enable latched off; re-enabled at line 300
      set_lens(324, 325, 4);
      chk_pass = 1'b1;
      run_frame(1, 1, 300, 1'b1, -1, 1'b0);
      check("pass_f4", pass_err, 0);
      check("f4_h272", obuf[198][272], {6'h10, 6'h06, 6'h16});
      pass_err = 0;

      // Frame 5: short lines suppress, long lines 250/251 still overlay
      set_lens(196, 200, 200);
      set_lens(250, 251, 800);
      run_frame(1, 2, -1, 1'b0, -1, 1'b0);
      check("pass_f5", pass_err, 0);
      check("f5_short", obuf[198][100], {6'h24, 6'h06, 6'h22});
      check("f5_long", obuf[251][300], {6'h36, 6'h1D, 6'h0B});
      pass_err = 0;

      // Frame 6: reset mid-line 198, remainder must pass through
      set_lens(250, 251, 4);
      set_lens(196, 200, 800);
      chk_pass = 1'b0;
      run_frame(1, 0, -1, 1'b0, 198, 1'b0);
      check("f6_pre_rst", obuf[198][300], {6'h36, 6'h03, 6'h15});
      check("pass_f6", pass_err, 0);

      check("sync_align", sync_err, 0);
      check("ce_hold", hold_err, 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
